// File: rtl/ddr3_read_ring_buffer_if.sv
// ddr3_read_ring_buffer_if: capture-side and drain-side signals of the DDR3 read ring buffer
interface ddr3_read_ring_buffer_if #(parameter int DATA_W = 16, parameter int DEPTH = 16);
   logic                    listen;
   logic                    bc4;
   logic                    dqs_valid;
   logic [DATA_W-1:0]       din_rise;
   logic [DATA_W-1:0]       din_fall;
   logic                    rd_en;
   logic [DATA_W-1:0]       dout;
   logic                    dout_valid;
   logic                    empty;
   logic                    full;
   logic [$clog2(DEPTH):0]  level;
   logic                    burst_done;
   logic                    timeout_err;
   logic                    overflow;
   modport master (output listen, bc4, dqs_valid, din_rise, din_fall, rd_en,
                   input  dout, dout_valid, empty, full, level, burst_done, timeout_err, overflow);
   modport slave  (input  listen, bc4, dqs_valid, din_rise, din_fall, rd_en,
                   output dout, dout_valid, empty, full, level, burst_done, timeout_err, overflow);
endinterface

// File: rtl/ddr3_read_ring_buffer.sv
// ddr3_read_ring_buffer: captures BL8/BC4 read bursts as rise/fall pairs into a circular store drained in order
module ddr3_read_ring_buffer #(
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 15
) (
   input logic                      clock,
   input logic                      reset,
   ddr3_read_ring_buffer_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
   state_t            state;
   logic [2:0]        beats_left;
   logic [TW-1:0]     tmo;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              pop, take, wr;
   logic [AW+1:0]     space;
   logic [AW:0]       nxt_level;
   // space check counts this cycle's pop so a pair can land in the slot being freed
   always_comb begin
      pop       = bus.rd_en & ~bus.empty;
      take      = bus.dqs_valid & (state != IDLE | bus.listen);
      space     = (AW+2)'(DEPTH) - {1'b0, bus.level} + {{(AW+1){1'b0}}, pop};
      wr        = take & (space >= (AW+2)'(2));
      nxt_level = bus.level + (wr ? (AW+1)'(2) : '0) - {{AW{1'b0}}, pop};
   end
   // storage has no reset; a read in the same cycle sees the old contents
   always_ff @(posedge clock) begin
      if (wr) begin
         mem[wr_ptr]           <= bus.din_rise;
         mem[AW'(wr_ptr + 1'b1)] <= bus.din_fall;
      end
   end
   // pointers, occupancy, read data and sticky overflow
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         bus.level      <= '0;
         bus.empty      <= 1'b1;
         bus.full       <= 1'b0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         bus.dout_valid <= pop;
         if (pop) begin
            bus.dout <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         if (wr) wr_ptr <= wr_ptr + AW'(2);
         if (take & ~wr) bus.overflow <= 1'b1;
         bus.level <= nxt_level;
         bus.empty <= nxt_level == '0;
         bus.full  <= nxt_level == (AW+1)'(DEPTH);
      end
   end
   // burst tracking: arm on listen, count pairs down, abort on strobe timeout
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         beats_left      <= '0;
         tmo             <= '0;
         bus.burst_done  <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.burst_done  <= 1'b0;
         bus.timeout_err <= 1'b0;
         if (state == IDLE) begin
            if (bus.listen) begin
               tmo        <= '0;
               beats_left <= (bus.bc4 ? 3'd2 : 3'd4) - {2'b0, bus.dqs_valid};
               state      <= bus.dqs_valid ? CAPTURE : ARMED;
            end
         end else if (bus.dqs_valid) begin
            tmo            <= '0;
            beats_left     <= beats_left - 3'd1;
            bus.burst_done <= beats_left == 3'd1;
            state          <= beats_left == 3'd1 ? IDLE : CAPTURE;
         end else if (tmo == TW'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
         end else begin
            tmo <= tmo + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ddr3_read_ring_buffer.sv
// tb_ddr3_read_ring_buffer: directed and random stimulus checked against a queue-based reference model
module tb_ddr3_read_ring_buffer;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 15;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad   = 0;
   int nvalid;
   ddr3_read_ring_buffer_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();
   ddr3_read_ring_buffer #(.DATA_W(16), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clock = ~clock;
   logic [15:0] q[$];
   logic [15:0] m_dout;
   bit m_dv, m_bd, m_te, m_ov, act;
   int rem, gap;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      q.delete();
      act = 0; rem = 0; gap = 0;
      m_dout = '0; m_dv = 0; m_bd = 0; m_te = 0; m_ov = 0;
   endtask
   task automatic model_step();
      bit starting;
      m_dv = bus.rd_en && q.size() > 0;
      m_bd = 0;
      m_te = 0;
      if (m_dv) m_dout = q.pop_front();
      starting = !act && bus.listen;
      if (starting) begin
         act = 1; rem = bus.bc4 ? 2 : 4; gap = 0;
      end
      if (act && bus.dqs_valid) begin
         if (DEPTH - q.size() >= 2) begin
            q.push_back(bus.din_rise);
            q.push_back(bus.din_fall);
         end else m_ov = 1;
         rem--; gap = 0;
         if (rem == 0) begin act = 0; m_bd = 1; end
      end else if (act && !starting) begin
         gap++;
         if (gap == TIMEOUT) begin act = 0; m_te = 1; end
      end
   endtask
   task automatic check_all();
      chk("dout", bus.dout, m_dout);
      chk("dout_valid", bus.dout_valid, m_dv);
      chk("level", bus.level, q.size());
      chk("empty", bus.empty, q.size() == 0);
      chk("full", bus.full, q.size() == DEPTH);
      chk("burst_done", bus.burst_done, m_bd);
      chk("timeout_err", bus.timeout_err, m_te);
      chk("overflow", bus.overflow, m_ov);
   endtask
   task automatic cyc(input logic l, input logic b, input logic v, input logic [15:0] r,
                      input logic [15:0] f, input logic rd);
      bus.listen = l; bus.bc4 = b; bus.dqs_valid = v;
      bus.din_rise = r; bus.din_fall = f; bus.rd_en = rd;
      @(posedge clock);
      model_step();
      #1;
      check_all();
      if (bus.dout_valid) nvalid++;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask
   task automatic pops(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
   endtask
   task automatic bl8(input logic [15:0] base);
      for (int k = 0; k < 4; k++)
         cyc(k == 0, 0, 1, base + 16'(2*k), base + 16'(2*k + 1), 0);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clock);
      reset = 1'b0;
   endtask
   initial begin
      bus.listen = 0; bus.bc4 = 0; bus.dqs_valid = 0;
      bus.din_rise = 0; bus.din_fall = 0; bus.rd_en = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      @(negedge clock);
      reset = 1'b0;
      // BL8 with listen one cycle ahead of the strobe, then drain in order
      cyc(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, 16'h1000 + 16'(2*k), 16'h1001 + 16'(2*k), 0);
      idle(1);
      pops(8);
      // BC4, then strobes while idle must not be stored
      cyc(1, 1, 1, 16'h2000, 16'h2001, 0);
      cyc(0, 0, 1, 16'h2002, 16'h2003, 0);
      cyc(0, 0, 1, 16'h2004, 16'h2005, 0);
      cyc(0, 0, 1, 16'h2006, 16'h2007, 0);
      pops(5);
      // timeout while armed, and after one pair
      cyc(1, 0, 0, 0, 0, 0);
      idle(17);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 16'h3000, 16'h3001, 0);
      idle(17);
      pops(3);
      // overflow: three BL8 bursts with no reads
      bl8(16'h4000); bl8(16'h4100); bl8(16'h4200);
      idle(2);
      // concurrency at level 15, then drain past empty
      do_reset();
      bl8(16'h5000); bl8(16'h5100);
      pops(1);
      cyc(1, 1, 1, 16'h5200, 16'h5201, 1);
      idle(17);
      nvalid = 0;
      pops(20);
      chk("drain_pulses", nvalid, 16);
      // reset on the second beat of a BL8, then a clean burst
      cyc(1, 0, 1, 16'h6000, 16'h6001, 0);
      bus.dqs_valid = 1; bus.din_rise = 16'h6002; bus.din_fall = 16'h6003;
      do_reset();
      bl8(16'h7000);
      idle(1);
      pops(9);
      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 1) == 1,
             16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
